// File: rtl/sc_psrandom_arbiter.sv
// Two-requester round-robin arbiter that hands out words from an external LFSR.
// Seeding loads the LFSR, a warm-up of STRIDE shifts follows, and every capture
// is spaced at least STRIDE clocks from the previous one.
module sc_psrandom_arbiter #(
    parameter int unsigned RegGENERAL_DATAWIDTH = 8,
    parameter int unsigned STRIDE               = 8
) (
    input  logic                              SC_PSRANDOM_ARBITER_CLOCK_50,
    input  logic                              SC_PSRANDOM_ARBITER_RESET_InLow,
    input  logic                              SC_PSRANDOM_ARBITER_SEEDREQ_InHigh,
    input  logic [RegGENERAL_DATAWIDTH-5:0]   SC_PSRANDOM_ARBITER_SEED_InBUS,
    input  logic                              SC_PSRANDOM_ARBITER_REQ0_InHigh,
    input  logic                              SC_PSRANDOM_ARBITER_REQ1_InHigh,
    output logic                              SC_PSRANDOM_ARBITER_GNT0_OutHigh,
    output logic                              SC_PSRANDOM_ARBITER_GNT1_OutHigh,
    output logic [RegGENERAL_DATAWIDTH-1:0]   SC_PSRANDOM_ARBITER_data_OutBUS,
    output logic                              SC_PSRANDOM_ARBITER_READY_OutHigh,
    output logic                              SC_PSRANDOM_ARBITER_LFSRLOAD_OutHigh,
    output logic [RegGENERAL_DATAWIDTH-5:0]   SC_PSRANDOM_ARBITER_LFSRSEED_OutBUS,
    input  logic [RegGENERAL_DATAWIDTH-1:0]   SC_PSRANDOM_ARBITER_LFSRdata_InBUS
);

    localparam int unsigned DataW = RegGENERAL_DATAWIDTH;
    localparam int unsigned SeedW = RegGENERAL_DATAWIDTH - 4;
    localparam int unsigned CntW  = 4;

    // Last counter value of the warm-up and cool-down phases.
    localparam logic [CntW-1:0] WarmLast = CntW'(STRIDE - 1);
    localparam logic [CntW-1:0] CoolLast = (STRIDE > 2) ? CntW'(STRIDE - 3) : '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEED = 3'd1,
        ST_WARM = 3'd2,
        ST_ARB  = 3'd3,
        ST_GNT  = 3'd4,
        ST_COOL = 3'd5
    } state_e;

    logic clk;
    logic rst_n;
    logic seedreq;
    logic req0;
    logic req1;

    assign clk     = SC_PSRANDOM_ARBITER_CLOCK_50;
    assign rst_n   = SC_PSRANDOM_ARBITER_RESET_InLow;
    assign seedreq = SC_PSRANDOM_ARBITER_SEEDREQ_InHigh;
    assign req0    = SC_PSRANDOM_ARBITER_REQ0_InHigh;
    assign req1    = SC_PSRANDOM_ARBITER_REQ1_InHigh;

    state_e            state_q,    state_d;
    logic [SeedW-1:0]  seed_q,     seed_d;
    logic [CntW-1:0]   cnt_q,      cnt_d;
    logic [DataW-1:0]  data_q,     data_d;
    logic              gnt0_q,     gnt0_d;
    logic              gnt1_q,     gnt1_d;
    logic              ready_q,    ready_d;
    logic              lfsrload_q, lfsrload_d;
    logic              last_q,     last_d;

    logic              any_req_c;
    logic              winner_c;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        any_req_c = req0 | req1;
        winner_c  = 1'b0;
        if (req0 && req1) begin
            winner_c = ~last_q;
        end else begin
            winner_c = req1;
        end
    end

    // Next-state, capture and grant decisions.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;

        if (seedreq) begin
            // Reseed wins over everything, including a capture due this cycle.
            seed_d  = SC_PSRANDOM_ARBITER_SEED_InBUS;
            cnt_d   = '0;
            state_d = ST_SEED;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SEED: begin
                    cnt_d   = '0;
                    state_d = ST_WARM;
                end
                ST_WARM: begin
                    if (cnt_q == WarmLast) begin
                        cnt_d   = '0;
                        state_d = ST_ARB;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ST_ARB: begin
                    if (any_req_c) begin
                        data_d  = SC_PSRANDOM_ARBITER_LFSRdata_InBUS;
                        last_d  = winner_c;
                        gnt0_d  = ~winner_c;
                        gnt1_d  = winner_c;
                        state_d = ST_GNT;
                    end
                end
                ST_GNT: begin
                    cnt_d = '0;
                    if (STRIDE > 2) begin
                        state_d = ST_COOL;
                    end else begin
                        state_d = ST_ARB;
                    end
                end
                ST_COOL: begin
                    if (cnt_q == CoolLast) begin
                        cnt_d   = '0;
                        state_d = ST_ARB;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        ready_d    = (state_d == ST_ARB) || (state_d == ST_GNT) || (state_d == ST_COOL);
        lfsrload_d = (state_d != ST_IDLE) && (state_d != ST_SEED);
    end

    // State and output registers; reset drops any grant in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seed_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ready_q    <= 1'b0;
            lfsrload_q <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ready_q    <= ready_d;
            lfsrload_q <= lfsrload_d;
            last_q     <= last_d;
        end
    end

    assign SC_PSRANDOM_ARBITER_GNT0_OutHigh     = gnt0_q;
    assign SC_PSRANDOM_ARBITER_GNT1_OutHigh     = gnt1_q;
    assign SC_PSRANDOM_ARBITER_data_OutBUS      = data_q;
    assign SC_PSRANDOM_ARBITER_READY_OutHigh    = ready_q;
    assign SC_PSRANDOM_ARBITER_LFSRLOAD_OutHigh = lfsrload_q;
    assign SC_PSRANDOM_ARBITER_LFSRSEED_OutBUS  = seed_q;

endmodule
